// File: rtl/uart_rx_sampler.sv
// 8N1 serial byte receiver: two-flop line synchroniser, mid-bit sampling,
// start-glitch rejection, stop-bit check and break (line-held-low) lockout.
module uart_rx_sampler #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic             sync1_q;
  logic             sync2_q;
  logic [2:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       sh_q,      sh_d;
  logic [7:0]       data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             ferr_q,    ferr_d;
  logic             busy_q;
  logic             rx_s;

  assign rx_s = sync2_q;

  // State and datapath registers; the synchroniser runs regardless of ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= rx_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // Next-state and pulse generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    sh_d      = sh_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    if (!ena) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          // Start bit must still be low at its mid-point, else it was a glitch.
          if (cnt_q == CNT_HALF) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_FULL) begin
            sh_d  = {rx_s, sh_q[7:1]};
            cnt_d = '0;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_d = '0;
            if (rx_s) begin
              data_d  = sh_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT: begin
          // A held-low line (break) must return high before a new start is accepted.
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at 16 clocks per bit; expected pulses are
// queued as frames are driven and matched against the DUT output as it appears.
module tb_uart_rx_sampler;

  localparam int unsigned CPB = 16;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int   n_assert;
  int   n_fail;
  int   cyc;
  int   last_pulse_cyc;
  int   n_valid;
  int   n_ferr;
  logic [7:0] last_good;
  exp_t exp_q[$];

  uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cyc > 2) begin
      check("pulse_exclusive", 32'(data_valid & frame_err), 32'd0);
      if (data_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, data_valid, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 32'(frame_err), 32'(e.err));
          if (e.err) begin
            check("data_hold_on_ferr", 32'(data_out), 32'(last_good));
            n_ferr++;
          end else begin
            check("data_out", 32'(data_out), 32'(e.data));
            last_good = e.data;
            n_valid++;
          end
          last_pulse_cyc = cyc;
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    exp_t e;
    e.err  = ~stop_bit;
    e.data = b;
    exp_q.push_back(e);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_bit, CPB);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    hold(1'b0, CPB);
    for (int i = 0; i < nbits; i++) hold(b[i], CPB);
  endtask

  initial begin
    int t_fall;
    int lat;
    int bc;
    int nv;
    n_assert = 0;
    n_fail = 0;
    cyc = 0;
    last_pulse_cyc = 0;
    n_valid = 0;
    n_ferr = 0;
    last_good = 8'h00;
    rst = 1'b1;
    ena = 1'b1;
    rx_in = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    hold(1'b1, 8);

    // Single byte with latency measurement
    nv = n_valid;
    t_fall = cyc;
    send_frame(8'hA5, 1'b1);
    lat = last_pulse_cyc - t_fall;
    check("a5_pulse_count", 32'(n_valid - nv), 32'd1);
    check("a5_latency_in_window", 32'(lat >= 153 && lat <= 155), 32'd1);
    @(negedge clk);
    check("a5_busy_after", 32'(busy), 32'd0);
    check("a5_data_out", 32'(data_out), 32'hA5);
    @(posedge clk);
    #1;
    hold(1'b1, 20);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    hold(1'b1, 20);
    check("b2b_data_out", 32'(data_out), 32'hFF);

    // Start-bit glitch
    bc = 0;
    rx_in = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) rx_in = 1'b1;
      @(negedge clk);
      if (busy) bc++;
      @(posedge clk);
      #1;
    end
    check("glitch_busy_window", 32'(bc >= 1 && bc <= (CPB / 2) + 1), 32'd1);
    check("glitch_idle", 32'(busy), 32'd0);
    hold(1'b1, 10);

    // Framing error followed by a break, then recovery
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 10);
    send_frame(8'h3C, 1'b0);
    hold(1'b0, 64);
    check("break_busy_held", 32'(busy), 32'd1);
    hold(1'b1, 4);
    check("break_released", 32'(busy), 32'd0);
    check("ferr_data_kept", 32'(data_out), 32'h5A);
    hold(1'b1, 28);
    send_frame(8'h11, 1'b1);
    hold(1'b1, 10);
    check("after_break_data", 32'(data_out), 32'h11);

    // Abort by reset mid-frame
    send_partial(8'hC3, 3);
    rst = 1'b1;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    check("abort_rst_busy", 32'(busy), 32'd0);
    check("abort_rst_data", 32'(data_out), 32'h00);
    @(posedge clk);
    #1;
    hold(1'b1, 40);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 10);
    check("abort_rst_rx", 32'(data_out), 32'h81);

    // Abort by dropping ena mid-frame
    nv = n_valid;
    send_partial(8'hC3, 3);
    ena = 1'b0;
    rx_in = 1'b1;
    @(posedge clk);
    #1;
    ena = 1'b1;
    @(negedge clk);
    check("abort_ena_busy", 32'(busy), 32'd0);
    check("abort_ena_data", 32'(data_out), 32'h81);
    @(posedge clk);
    #1;
    hold(1'b1, 40);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 40);
    check("abort_ena_pulses", 32'(n_valid - nv), 32'd1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("total_valid", 32'(n_valid), 32'd7);
    check("total_ferr", 32'(n_ferr), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Serial byte receiver inside the top-level design; consumes one dedicated input pin (ui_in bit chosen at top level) and feeds the command/datapath logic.
- Synchronises the asynchronous line, detects and validates the start bit, mid-bit samples 8 data bits LSB-first, and checks the stop bit (8N1).
- Emits a one-cycle valid pulse with the byte, or a one-cycle framing-error pulse.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per serial bit; legal range ≥ 4 (87 ≈ 10 MHz / 115200).
- HALF_BIT, CLKS_PER_BIT/2 (integer divide), start-bit mid-point check offset.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- ena  input  1  block enable (top-level ena)
- rx_in  input  1  raw asynchronous serial line, idle high
- data_out  output  8  last correctly received byte
- data_valid  output  1  one-cycle pulse: data_out updated this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high whenever state ≠ IDLE

Behaviour:
- Reset:
  - Reset is sampled on the clk rising edge; it is synchronous and active-high.
  - Reset values: state=IDLE, data_out=0x00, data_valid=0, frame_err=0, busy=0, counters=0.
  - Both synchroniser flops reset to 1 (idle line).
  - Reset mid-frame discards the partial byte; it produces no pulse.
- Synchroniser:
  - 2-flop chain; rx_s = second flop.
  - 2-cycle latency from rx_in to rx_s.
  - All decisions use rx_s only.
- Counter: cnt, width clog2(CLKS_PER_BIT); bit_idx 3 bits; shift register sh[7:0].
- IDLE:
  - rx_s==0 -> START, cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==HALF_BIT-1: if rx_s==0 -> DATA, cnt=0, bit_idx=0; else -> IDLE (glitch rejected, no pulse).
- DATA:
  - At cnt==CLKS_PER_BIT-1: sh <= {rx_s, sh[7:1]} (LSB first), cnt=0.
  - If bit_idx==7 -> STOP; else bit_idx++.
  - Otherwise cnt++.
- STOP:
  - At cnt==CLKS_PER_BIT-1:
    - rx_s==1: data_out<=sh, data_valid=1 for exactly this cycle, -> IDLE.
    - rx_s==0: frame_err=1 for one cycle, data_out unchanged, -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s==1, then -> IDLE.
  - Prevents a break condition (line held low) from being treated as new start bits.
- Back-to-back frames: after a good stop bit, IDLE sees the next start bit as soon as rx_s falls. No idle gap is required; the half-bit stop is tolerated.
- ena:
  - While ena==0, state is forced to IDLE with cnt=0 and no pulses.
  - data_out holds its value; the synchroniser keeps running.
  - Deasserting ena mid-frame aborts the frame silently.
- Pulses: data_valid and frame_err are never high simultaneously. Both are 0 on every cycle other than their defined event.
- Precedence: rst > ena==0 > FSM.

Test Plan:
- Reset, CLKS_PER_BIT=16: rst=1 for 2 cycles, rx_in=1, ena=1 -> data_out=0x00, data_valid=0, frame_err=0, busy=0.
- Single byte 0xA5, 8N1 at 16 clk/bit:
  - Exactly one data_valid pulse, with data_out=0xA5 and frame_err=0.
  - The pulse occurs 2+8+8·16+16 = 154 cycles (±1) after the rx_in falling edge.
  - busy falls on the following cycle.
- Back-to-back 0x00 then 0xFF with no idle bits between frames -> two data_valid pulses, data_out=0x00 then 0xFF. No frame_err.
- Glitch: rx_in low for 4 cycles, then high -> busy high for at most HALF_BIT+1 cycles, then IDLE. No data_valid and no frame_err.
- Framing error and break:
  - Stimulus: send 0x3C (after a prior good 0x5A) with the stop bit low, then hold rx_in low for 64 cycles, then high, then send 0x11.
  - Response: one frame_err pulse, no data_valid, and data_out stays 0x5A.
  - No frame starts during the low hold; 0x11 is then received correctly.
- Abort:
  - rst=1 for one cycle after 3 data bits of 0xC3, then send 0x81 -> only 0x81 reported.
  - Repeat with ena=0 pulsed mid-frame instead of rst -> same result.
